bit_destuffer: RTL and testbench

BIT_DESTUFFER -- requirements
Module: bit_destuffer

---
 rtl/bit_destuffer.sv | 120 ++++++++++++
 tb/tb_bit_destuffer.sv | 178 +++++++++++++++++
 2 files changed

// File: rtl/bit_destuffer.sv
// CAN bit destuffer: drops the bit that follows STUFF_LEN identical bits inside the stuff region.
// Latency: outputs are registered and appear 1 clk after the sp cycle that sampled the bit.
// Backpressure: none; one bit is accepted per sp strobe and all state holds while sp=0.
module bit_destuffer #(
   parameter int STUFF_LEN = 5
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       sp,
   input  logic       rx,
   input  logic       f_stf,
   output logic       bit_out,
   output logic       bit_valid,
   output logic       stuff_drop,
   output logic       stuff_viol,
   output logic [7:0] dbit_cnt
);

   typedef enum logic [1:0] {
      ST_PASS = 2'd0,
      ST_RUN  = 2'd1,
      ST_SKIP = 2'd2
   } state_t;

   localparam logic [2:0] STUFF_LEN_C = 3'(STUFF_LEN);

   state_t     state_q, state_d;
   logic [2:0] run_q, run_d;
   logic       last_q, last_d;
   logic [7:0] dcnt_q, dcnt_d;
   logic       out_q, out_d;
   logic       vld_q, vld_d;
   logic       drop_q, drop_d;
   logic       viol_q, viol_d;

   // Next-state and output decode; everything holds and strobes stay low unless sp samples a bit.
   always_comb begin
      state_d = state_q;
      run_d   = run_q;
      last_d  = last_q;
      dcnt_d  = dcnt_q;
      out_d   = out_q;
      vld_d   = 1'b0;
      drop_d  = 1'b0;
      viol_d  = 1'b0;
      if (sp) begin
         if (f_stf) begin
            // Outside the stuff region every bit passes through; the count is kept for inspection.
            state_d = ST_PASS;
            run_d   = 3'd0;
            out_d   = rx;
            vld_d   = 1'b1;
         end else begin
            unique case (state_q)
               ST_PASS: begin
                  // Entering the stuff region: this bit opens a fresh run and restarts the count.
                  state_d = ST_RUN;
                  run_d   = 3'd1;
                  last_d  = rx;
                  dcnt_d  = 8'd1;
                  out_d   = rx;
                  vld_d   = 1'b1;
               end
               ST_RUN: begin
                  run_d   = (rx == last_q) ? run_q + 3'd1 : 3'd1;
                  last_d  = rx;
                  out_d   = rx;
                  vld_d   = 1'b1;
                  if (dcnt_q != 8'hFF) begin
                     dcnt_d = dcnt_q + 8'd1;
                  end
                  state_d = (run_d == STUFF_LEN_C) ? ST_SKIP : ST_RUN;
               end
               ST_SKIP: begin
                  // The stuff bit is discarded; a same-polarity stuff bit is flagged but still dropped.
                  state_d = ST_RUN;
                  run_d   = 3'd1;
                  last_d  = rx;
                  drop_d  = 1'b1;
                  viol_d  = (rx == last_q);
               end
               default: begin
                  state_d = ST_PASS;
                  run_d   = 3'd0;
               end
            endcase
         end
      end
   end

   // State and output registers with asynchronous reset.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q <= ST_PASS;
         run_q   <= 3'd0;
         last_q  <= 1'b1;
         dcnt_q  <= 8'd0;
         out_q   <= 1'b1;
         vld_q   <= 1'b0;
         drop_q  <= 1'b0;
         viol_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         run_q   <= run_d;
         last_q  <= last_d;
         dcnt_q  <= dcnt_d;
         out_q   <= out_d;
         vld_q   <= vld_d;
         drop_q  <= drop_d;
         viol_q  <= viol_d;
      end
   end

   assign bit_out    = out_q;
   assign bit_valid  = vld_q;
   assign stuff_drop = drop_q;
   assign stuff_viol = viol_q;
   assign dbit_cnt   = dcnt_q;

endmodule

// File: tb/tb_bit_destuffer.sv
// Directed bench for bit_destuffer with STUFF_LEN=5.
// Inputs change on the falling edge; outputs are checked on the falling edge after the sampling edge.
// Every expected value below is hand-derived from the destuffing rules.
module tb_bit_destuffer;

   logic       clk;
   logic       reset;
   logic       sp;
   logic       rx;
   logic       f_stf;
   logic       bit_out;
   logic       bit_valid;
   logic       stuff_drop;
   logic       stuff_viol;
   logic [7:0] dbit_cnt;

   int n_assert = 0;
   int n_fail   = 0;

   bit_destuffer #(.STUFF_LEN(5)) dut (
      .clk        (clk),
      .reset      (reset),
      .sp         (sp),
      .rx         (rx),
      .f_stf      (f_stf),
      .bit_out    (bit_out),
      .bit_valid  (bit_valid),
      .stuff_drop (stuff_drop),
      .stuff_viol (stuff_viol),
      .dbit_cnt   (dbit_cnt)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // {valid, out (only meaningful when valid), drop, viol}
   task automatic chk_out(input string tag, input logic v, input logic o, input logic d, input logic vi);
      logic [3:0] obs, exp;
      obs = {bit_valid, bit_valid ? bit_out : 1'b0, stuff_drop, stuff_viol};
      exp = {v, v ? o : 1'b0, d, vi};
      chk(tag, 32'(obs), 32'(exp));
   endtask

   // One sp strobe carrying one bus bit; returns while that bit's outputs are visible.
   task automatic send(input logic r, input logic f);
      @(negedge clk);
      sp = 1'b1; rx = r; f_stf = f;
      @(negedge clk);
      sp = 1'b0;
   endtask

   initial begin
      int drops;
      logic bo;
      logic r;
      reset = 1'b1; sp = 1'b0; rx = 1'b0; f_stf = 1'b0;

      // Reset with sp active: nothing may be sampled, release lands inside the sp cycle.
      @(negedge clk);
      sp = 1'b1;
      @(posedge clk);
      #1;
      reset = 1'b0;
      @(negedge clk);
      sp = 1'b0;
      chk_out("reset_strobes", 1'b0, 1'b0, 1'b0, 1'b0);
      chk("reset_bit_out", 32'(bit_out), 32'd1);
      chk("reset_dbit_cnt", 32'(dbit_cnt), 32'd0);

      // Five zeros delivered, sixth (a 1) dropped without violation, seventh delivered.
      for (int i = 0; i < 5; i++) begin
         send(1'b0, 1'b0);
         chk_out($sformatf("run0_bit%0d", i), 1'b1, 1'b0, 1'b0, 1'b0);
         chk($sformatf("run0_cnt%0d", i), 32'(dbit_cnt), 32'(i + 1));
      end
      send(1'b1, 1'b0);
      chk_out("stuff1_drop", 1'b0, 1'b0, 1'b1, 1'b0);
      chk("stuff1_cnt", 32'(dbit_cnt), 32'd5);
      send(1'b1, 1'b0);
      chk_out("after_stuff1", 1'b1, 1'b1, 1'b0, 1'b0);
      chk("after_stuff1_cnt", 32'(dbit_cnt), 32'd6);

      // Leave the stuff region: bit passes, count holds.
      send(1'b1, 1'b1);
      chk_out("exit_pass", 1'b1, 1'b1, 1'b0, 1'b0);
      chk("exit_cnt_hold", 32'(dbit_cnt), 32'd6);

      // Six ones: sixth dropped as a violation; run restarts at 1 so four more pass then a drop.
      for (int i = 0; i < 5; i++) begin
         send(1'b1, 1'b0);
         chk_out($sformatf("run1_bit%0d", i), 1'b1, 1'b1, 1'b0, 1'b0);
      end
      chk("run1_cnt", 32'(dbit_cnt), 32'd5);
      send(1'b1, 1'b0);
      chk_out("viol1", 1'b0, 1'b0, 1'b1, 1'b1);
      for (int i = 0; i < 4; i++) begin
         send(1'b1, 1'b0);
         chk_out($sformatf("restart_bit%0d", i), 1'b1, 1'b1, 1'b0, 1'b0);
      end
      chk("restart_cnt", 32'(dbit_cnt), 32'd9);
      send(1'b1, 1'b0);
      chk_out("viol2", 1'b0, 1'b0, 1'b1, 1'b1);
      chk("viol2_cnt", 32'(dbit_cnt), 32'd9);

      // Back to PASS, then three zeros into a new region.
      send(1'b0, 1'b1);
      chk_out("pass2", 1'b1, 1'b0, 1'b0, 1'b0);
      for (int i = 0; i < 3; i++) send(1'b0, 1'b0);
      chk("enter2_cnt", 32'(dbit_cnt), 32'd3);

      // sp idle with inputs toggling: no strobes, nothing moves.
      bo = bit_out;
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         rx = ~rx; f_stf = ~f_stf;
         chk_out($sformatf("idle%0d", i), 1'b0, 1'b0, 1'b0, 1'b0);
      end
      chk("idle_bit_out", 32'(bit_out), 32'(bo));
      chk("idle_cnt", 32'(dbit_cnt), 32'd3);

      // Fourth zero, then f_stf=1 with rx=0: passed, not dropped; re-entry restarts count at 1.
      send(1'b0, 1'b0);
      chk("run4_cnt", 32'(dbit_cnt), 32'd4);
      send(1'b0, 1'b1);
      chk_out("exit_run4", 1'b1, 1'b0, 1'b0, 1'b0);
      chk("exit_run4_cnt", 32'(dbit_cnt), 32'd4);
      send(1'b0, 1'b0);
      chk_out("reenter", 1'b1, 1'b0, 1'b0, 1'b0);
      chk("reenter_cnt", 32'(dbit_cnt), 32'd1);

      // Four more zeros reach the stuff point; reset while SKIP is pending.
      for (int i = 0; i < 4; i++) send(1'b0, 1'b0);
      chk("pre_skip_cnt", 32'(dbit_cnt), 32'd5);
      @(negedge clk);
      reset = 1'b1;
      #1;
      chk_out("midreset_strobes", 1'b0, 1'b0, 1'b0, 1'b0);
      chk("midreset_bit_out", 32'(bit_out), 32'd1);
      chk("midreset_cnt", 32'(dbit_cnt), 32'd0);
      @(negedge clk);
      reset = 1'b0;
      send(1'b0, 1'b0);
      chk_out("post_reset_bit", 1'b1, 1'b0, 1'b0, 1'b0);
      chk("post_reset_cnt", 32'(dbit_cnt), 32'd1);

      // Alternating bits: never stuffed; count saturates at 255 (started at 1 with last bit 0).
      drops = 0;
      r = 1'b1;
      for (int k = 1; k <= 300; k++) begin
         send(r, 1'b0);
         if (stuff_drop || !bit_valid) drops++;
         if (k == 253) chk("alt_cnt_254", 32'(dbit_cnt), 32'd254);
         if (k == 254) chk("alt_cnt_255", 32'(dbit_cnt), 32'd255);
         r = ~r;
      end
      chk("alt_no_drop", 32'(drops), 32'd0);
      chk("alt_cnt_sat", 32'(dbit_cnt), 32'd255);

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

   // Overall time bound so the run always ends.
   initial begin
      #200000;
      $display("FAIL timeout: simulation did not complete");
      $fatal(1, "timeout");
   end

endmodule
